// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, entry points and fetch state encoding
package cpu_pkg;

  localparam int AW = 11;
  localparam int IW = 9;

  localparam logic [AW-1:0] PROG0_BASE_DEF = 11'd0;
  localparam logic [AW-1:0] PROG1_BASE_DEF = 11'd512;
  localparam logic [AW-1:0] PROG2_BASE_DEF = 11'd1024;
  localparam logic [AW-1:0] LAST_ADDR_DEF  = 11'd2047;
  localparam logic [IW-1:0] HALT_WORD_DEF  = 9'b111111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit up counter with clear that sticks at all-ones
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 16'd0;
    end else if (enable && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter and fetch FSM in front of the instruction ROM
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [AW-1:0] PROG0_BASE = PROG0_BASE_DEF,
  parameter logic [AW-1:0] PROG1_BASE = PROG1_BASE_DEF,
  parameter logic [AW-1:0] PROG2_BASE = PROG2_BASE_DEF,
  parameter logic [IW-1:0] HALT_WORD  = HALT_WORD_DEF,
  parameter logic [AW-1:0] LAST_ADDR  = LAST_ADDR_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [1:0]    ProgSel,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic [AW-1:0] BranchTarget,
  input  logic [IW-1:0] InstIn,
  output logic [AW-1:0] InstAddress,
  output logic          InstValid,
  output logic          Busy,
  output logic          Done,
  output logic          Fault,
  output logic [15:0]   ExecCount
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  logic          cnt_clr;
  logic          is_halt;
  logic          inst_valid;
  logic [AW-1:0] start_base;

  assign is_halt    = (InstIn == HALT_WORD);
  assign inst_valid = (state_q == ST_RUN) && !Stall && !is_halt;

  always_comb begin
    case (ProgSel)
      2'd0:    start_base = PROG0_BASE;
      2'd1:    start_base = PROG1_BASE;
      default: start_base = PROG2_BASE;
    endcase
  end

  // Stall > halt > branch > overrun > increment; Start only matters outside RUN.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    fault_d = fault_q;
    cnt_clr = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!Stall) begin
          if (is_halt) begin
            state_d = ST_HALTED;
            done_d  = 1'b1;
          end else if (BranchEn) begin
            pc_d = BranchTarget;
          end else if (pc_q == LAST_ADDR) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      default: begin
        if (Start) begin
          done_d = 1'b0;
          if (ProgSel != 2'd3) begin
            state_d = ST_RUN;
            pc_d    = start_base;
            fault_d = 1'b0;
            cnt_clr = 1'b1;
          end else begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  sat_counter16 u_exec_count (
    .clk    (Clk),
    .reset  (Reset),
    .clear  (cnt_clr),
    .enable (inst_valid),
    .count  (ExecCount)
  );

  assign InstAddress = pc_q;
  assign InstValid   = inst_valid;
  assign Busy        = (state_q == ST_RUN);
  assign Done        = done_q;
  assign Fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized and directed checks of fetch_sequencer against a program-level model
module tb_fetch_sequencer;

  localparam logic [8:0] HALT = 9'h1FF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0, Start = 1'b0, Stall = 1'b0, BranchEn = 1'b0;
  logic [1:0]  ProgSel = 2'd0;
  logic [10:0] BranchTarget = 11'd0;
  logic [8:0]  InstIn;
  logic [10:0] InstAddress;
  logic        InstValid, Busy, Done, Fault;
  logic [15:0] ExecCount;

  logic [8:0]  rom [0:2047];
  assign InstIn = rom[InstAddress];

  always #5 Clk = ~Clk;

  fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Stall(Stall),
    .BranchEn(BranchEn), .BranchTarget(BranchTarget), .InstIn(InstIn),
    .InstAddress(InstAddress), .InstValid(InstValid), .Busy(Busy), .Done(Done),
    .Fault(Fault), .ExecCount(ExecCount)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: 0 idle, 1 running, 2 halted, 3 faulted
  int          m_state = 0;
  logic [10:0] m_pc = 0;
  logic        m_done = 0, m_fault = 0;
  logic [15:0] m_cnt = 0;

  function automatic logic [30:0] act_vec();
    return {InstAddress, InstValid, Busy, Done, Fault, ExecCount};
  endfunction

  function automatic logic [30:0] exp_vec();
    logic v;
    v = (m_state == 1) && !Stall && (rom[m_pc] != HALT);
    return {m_pc, v, (m_state == 1), m_done, m_fault, m_cnt};
  endfunction

  task automatic model_step();
    if (Reset) begin
      m_state = 0; m_pc = 0; m_done = 0; m_fault = 0; m_cnt = 0;
    end else if (m_state != 1) begin
      if (Start) begin
        m_done = 0;
        if (ProgSel == 2'd3) begin
          m_state = 3; m_fault = 1;
        end else begin
          m_state = 1; m_fault = 0; m_cnt = 0;
          m_pc = 11'(int'(ProgSel) * 512);
        end
      end
    end else if (!Stall) begin
      if (rom[m_pc] == HALT) begin
        m_state = 2; m_done = 1;
      end else begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (BranchEn) m_pc = BranchTarget;
        else if (m_pc == 11'd2047) begin m_state = 3; m_fault = 1; end
        else m_pc = m_pc + 11'd1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic fill_rom();
    for (int a = 0; a < 2048; a++) rom[a] = 9'($urandom_range(0, 510));
  endtask

  task automatic do_reset();
    Start = 0; Stall = 0; BranchEn = 0; Reset = 1;
    tick();
    Reset = 0;
  endtask

  task automatic launch(input logic [1:0] sel);
    ProgSel = sel; Start = 1;
    tick();
    Start = 0;
  endtask

  task automatic test_reset();
    fill_rom();
    Reset = 1; tick(); tick(); Reset = 0;
    #1; n_cmp++;
    if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL reset_vec act=%h exp=%h", act_vec(), exp_vec()); end
    n_cmp++;
    if ({InstAddress, Busy, Done, Fault, ExecCount} !== 30'd0) begin
      n_bad++; $display("FAIL reset_zero act=%h exp=0", {InstAddress, Busy, Done, Fault, ExecCount});
    end
  endtask

  task automatic test_basic();
    fill_rom(); rom[515] = HALT;
    do_reset(); launch(2'd1);
    for (int i = 0; i < 6; i++) begin
      #1; n_cmp++;
      if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL basic_cyc%0d act=%h exp=%h", i, act_vec(), exp_vec()); end
      tick();
    end
    #1; n_cmp++;
    if ({Done, Busy, InstAddress, ExecCount} !== {1'b1, 1'b0, 11'd515, 16'd3}) begin
      n_bad++; $display("FAIL basic_end act=%h exp=%h", {Done, Busy, InstAddress, ExecCount}, {1'b1, 1'b0, 11'd515, 16'd3});
    end
  endtask

  task automatic test_branch();
    fill_rom(); rom[600] = HALT;
    do_reset(); launch(2'd1);
    tick();
    BranchEn = 1; BranchTarget = 11'd600;
    #1; n_cmp++;
    if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL branch_at513 act=%h exp=%h", act_vec(), exp_vec()); end
    tick(); BranchEn = 0;
    #1; n_cmp++;
    if ({InstAddress, ExecCount} !== {11'd600, 16'd2}) begin
      n_bad++; $display("FAIL branch_target act=%h exp=%h", {InstAddress, ExecCount}, {11'd600, 16'd2});
    end
  endtask

  task automatic test_stall();
    fill_rom(); rom[515] = HALT;
    do_reset(); launch(2'd1);
    tick(); tick();
    Stall = 1;
    for (int i = 0; i < 4; i++) begin
      #1; n_cmp++;
      if ({InstAddress, InstValid, ExecCount} !== {11'd514, 1'b0, 16'd2} || act_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL stall_hold%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
      tick();
    end
    Stall = 0;
    for (int i = 0; i < 3; i++) begin
      #1; n_cmp++;
      if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL stall_resume%0d act=%h exp=%h", i, act_vec(), exp_vec()); end
      tick();
    end
    #1; n_cmp++;
    if ({Done, InstAddress, ExecCount} !== {1'b1, 11'd515, 16'd3}) begin
      n_bad++; $display("FAIL stall_end act=%h exp=%h", {Done, InstAddress, ExecCount}, {1'b1, 11'd515, 16'd3});
    end
  endtask

  task automatic test_illegal();
    launch(2'd3);
    #1; n_cmp++;
    if ({Fault, Done, Busy, InstAddress} !== {1'b1, 1'b0, 1'b0, 11'd515} || act_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL illegal_sel act=%h exp=%h", act_vec(), exp_vec());
    end
    rom[2] = HALT;
    launch(2'd0);
    #1; n_cmp++;
    if ({Fault, Busy, InstAddress} !== {1'b0, 1'b1, 11'd0}) begin
      n_bad++; $display("FAIL illegal_clear act=%h exp=%h", {Fault, Busy, InstAddress}, {1'b0, 1'b1, 11'd0});
    end
  endtask

  task automatic test_overrun();
    logic seen_zero;
    seen_zero = 0;
    fill_rom();
    do_reset(); launch(2'd2);
    BranchEn = 1; BranchTarget = 11'd2044;
    tick(); BranchEn = 0;
    for (int i = 0; i < 6; i++) begin
      #1; n_cmp++;
      if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL overrun_cyc%0d act=%h exp=%h", i, act_vec(), exp_vec()); end
      if (InstAddress === 11'd0) seen_zero = 1;
      tick();
    end
    #1; n_cmp++;
    if ({seen_zero, Fault, InstAddress, ExecCount} !== {1'b0, 1'b1, 11'd2047, 16'd5}) begin
      n_bad++; $display("FAIL overrun_end act=%h exp=%h", {seen_zero, Fault, InstAddress, ExecCount}, {1'b0, 1'b1, 11'd2047, 16'd5});
    end
  endtask

  task automatic test_reset_mid_run();
    fill_rom();
    do_reset(); launch(2'd1);
    BranchEn = 1; BranchTarget = 11'd700;
    tick(); BranchEn = 0;
    Reset = 1; tick(); Reset = 0;
    #1; n_cmp++;
    if ({InstAddress, Busy, Done, Fault, ExecCount} !== 30'd0 || act_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_mid_run act=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_halt_branch();
    fill_rom(); rom[513] = HALT;
    do_reset(); launch(2'd1);
    tick();
    BranchEn = 1; BranchTarget = 11'd100;
    tick(); BranchEn = 0;
    #1; n_cmp++;
    if ({Done, Busy, InstAddress, ExecCount} !== {1'b1, 1'b0, 11'd513, 16'd1}) begin
      n_bad++; $display("FAIL halt_beats_branch act=%h exp=%h", {Done, Busy, InstAddress, ExecCount}, {1'b1, 1'b0, 11'd513, 16'd1});
    end
  endtask

  task automatic test_random();
    for (int a = 0; a < 2048; a++)
      rom[a] = ($urandom_range(0, 31) == 0) ? HALT : 9'($urandom_range(0, 510));
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      Reset        = ($urandom_range(0, 199) == 0);
      Start        = ($urandom_range(0, 7) == 0);
      ProgSel      = 2'($urandom_range(0, 3));
      Stall        = ($urandom_range(0, 3) == 0);
      BranchEn     = ($urandom_range(0, 5) == 0);
      BranchTarget = 11'($urandom_range(0, 2047));
      #1; n_cmp++;
      if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL random_cyc%0d act=%h exp=%h", i, act_vec(), exp_vec()); end
      tick();
    end
    Reset = 0; Start = 0; Stall = 0; BranchEn = 0;
  endtask

  task automatic test_saturate();
    fill_rom();
    do_reset(); launch(2'd0);
    BranchEn = 1; BranchTarget = 11'd0;
    repeat (65540) tick();
    #1; n_cmp++;
    if (ExecCount !== 16'hFFFF || act_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL saturate act=%h exp=%h", act_vec(), exp_vec());
    end
    BranchEn = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_stall();
    test_illegal();
    test_overrun();
    test_reset_mid_run();
    test_halt_branch();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
